// File: rtl/mem_stage_if.sv
// Data bus interface for the MEM stage.
// Request/grant/rvalid handshake towards the data memory.
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores on the data bus and registers the MEM/WB result.
// Optional misaligned-access trap enabled with macro MEM_MISALIGN_CHK_EN.
module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_waddr_i,
    input  logic [31:0] rd_data_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [3:0]  mem_w_sel_i,
    input  logic [31:0] mem_data_i,
    mem_stage_if.master dbus,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] inst_addr_o,
    output logic        hold_flag_o
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic [4:0]            lrd_q, lrd_d;
    logic                  lwe_q, lwe_d;
    logic [31:0]           lpc_q, lpc_d;
    logic                  store_q, store_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           ext_q, ext_d;
    logic                  rd_we_q, rd_we_d;
    logic [4:0]            rd_waddr_q, rd_waddr_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [31:0]           inst_addr_q, inst_addr_d;

    logic       load, store, access;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [3:0] load_be;
    logic       unused_inst;

    assign funct3      = inst_i[14:12];
    assign off         = mem_waddr_i[1:0];
    assign load        = (inst_i[6:0] == 7'b0000011);
    assign store       = mem_we_i;
    assign access      = load | store;
    assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

`ifdef MEM_MISALIGN_CHK_EN
    logic mis;
    logic misalign_q, misalign_d;
    assign mis = (((funct3 == 3'b001) || (funct3 == 3'b101)) && off[0])
               || ((funct3 == 3'b010) && (off != 2'b00));
    assign misalign_o = misalign_q;
`endif

    // Extract and extend the addressed byte/halfword from a bus word.
    function automatic logic [31:0] extract(logic [2:0] f3, logic [1:0] o,
                                            logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Byte enables for a load, from its width and address offset.
    always_comb begin
        case (funct3[1:0])
            2'b00:   load_be = 4'b0001 << off;
            2'b01:   load_be = 4'b0011 << {off[1], 1'b0};
            default: load_be = 4'b1111;
        endcase
    end

    assign dbus.req    = (state_q == REQ);
    assign dbus.we     = store_q;
    assign dbus.addr   = addr_q;
    assign dbus.be     = be_q;
    assign dbus.wdata  = wdata_q;

    assign rd_we_o     = rd_we_q;
    assign rd_waddr_o  = rd_waddr_q;
    assign rd_data_o   = rd_data_q;
    assign inst_addr_o = inst_addr_q;

    // Next-state, transaction latching and MEM/WB result selection.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        off_d       = off_q;
        f3_d        = f3_q;
        lrd_d       = lrd_q;
        lwe_d       = lwe_q;
        lpc_d       = lpc_q;
        store_d     = store_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        ext_d       = ext_q;
        rd_we_d     = 1'b0;
        rd_waddr_d  = rd_waddr_q;
        rd_data_d   = rd_data_q;
        inst_addr_d = inst_addr_q;
        hold_flag_o = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!access) begin
                    rd_we_d     = rd_we_i;
                    rd_waddr_d  = rd_waddr_i;
                    rd_data_d   = rd_data_i;
                    inst_addr_d = inst_addr_i;
                end
`ifdef MEM_MISALIGN_CHK_EN
                else if (mis) begin
                    misalign_d = 1'b1;
                end
`endif
                else begin
                    hold_flag_o = 1'b1;
                    state_d     = REQ;
                    addr_d      = {mem_waddr_i[ADDR_WIDTH-1:2], 2'b00};
                    off_d       = off;
                    f3_d        = funct3;
                    lrd_d       = rd_waddr_i;
                    lwe_d       = rd_we_i;
                    lpc_d       = inst_addr_i;
                    store_d     = store;
                    be_d        = store ? mem_w_sel_i : load_be;
                    wdata_d     = mem_data_i;
                end
            end
            REQ: begin
                hold_flag_o = 1'b1;
                if (dbus.gnt) state_d = store_q ? DONE : WAIT_R;
            end
            WAIT_R: begin
                hold_flag_o = 1'b1;
                if (dbus.rvalid) begin
                    ext_d   = extract(f3_q, off_q, dbus.rdata);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d     = IDLE;
                rd_we_d     = store_q ? 1'b0 : lwe_q;
                rd_waddr_d  = lrd_q;
                rd_data_d   = ext_q;
                inst_addr_d = lpc_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            lrd_q       <= '0;
            lwe_q       <= 1'b0;
            lpc_q       <= '0;
            store_q     <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            ext_q       <= '0;
            rd_we_q     <= 1'b0;
            rd_waddr_q  <= '0;
            rd_data_q   <= '0;
            inst_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            lrd_q       <= lrd_d;
            lwe_q       <= lwe_d;
            lpc_q       <= lpc_d;
            store_q     <= store_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            ext_q       <= ext_d;
            rd_we_q     <= rd_we_d;
            rd_waddr_q  <= rd_waddr_d;
            rd_data_q   <= rd_data_d;
            inst_addr_q <= inst_addr_d;
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    // One-cycle misalignment pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random ALU/load/store traffic
// against a behavioural model of the load/store rules.
module tb_mem_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        rd_we_i;
    logic [4:0]  rd_waddr_i;
    logic [31:0] rd_data_i;
    logic        mem_we_i;
    logic [31:0] mem_waddr_i;
    logic [3:0]  mem_w_sel_i;
    logic [31:0] mem_data_i;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_data_o;
    logic [31:0] inst_addr_o;
    logic        hold_flag_o;
`ifdef MEM_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_if #(.ADDR_WIDTH(32)) dbus ();

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .rd_we_i     (rd_we_i),
        .rd_waddr_i  (rd_waddr_i),
        .rd_data_i   (rd_data_i),
        .mem_we_i    (mem_we_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_w_sel_i (mem_w_sel_i),
        .mem_data_i  (mem_data_i),
        .dbus        (dbus),
        .rd_we_o     (rd_we_o),
        .rd_waddr_o  (rd_waddr_o),
        .rd_data_o   (rd_data_o),
        .inst_addr_o (inst_addr_o),
        .hold_flag_o (hold_flag_o)
`ifdef MEM_MISALIGN_CHK_EN
        ,
        .misalign_o  (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected load byte enables from access width and address.
    function automatic logic [3:0] ref_be(input logic [2:0] f3,
                                          input logic [31:0] a);
        int unsigned o;
        o = a % 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << o);
        if (f3 == 3'd1 || f3 == 3'd5) return 4'(3 << ((o / 2) * 2));
        return 4'hF;
    endfunction

    // Expected register value of a load from the returned word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned o;
        int unsigned v;
        o = a % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * o)) % 256;
                if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (o / 2))) % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] legal_addr(input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] r;
        r = a;
`ifdef MEM_MISALIGN_CHK_EN
        if (f3[1:0] == 2'b01) r = a & 32'hFFFF_FFFE;
        if (f3[1:0] == 2'b10) r = a & 32'hFFFF_FFFC;
`endif
        return r;
    endfunction

    task automatic drive_nop();
        inst_i      = {25'h0, OP_ALU};
        inst_addr_i = 32'h0;
        rd_we_i     = 1'b0;
        rd_waddr_i  = 5'd0;
        rd_data_i   = 32'h0;
        mem_we_i    = 1'b0;
        mem_waddr_i = 32'h0;
        mem_w_sel_i = 4'h0;
        mem_data_i  = 32'h0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] data,
                          input logic [31:0] pc, input logic we);
        inst_i      = {17'h0, 3'b000, rd, OP_ALU};
        inst_addr_i = pc;
        rd_we_i     = we;
        rd_waddr_i  = rd;
        rd_data_i   = data;
        mem_we_i    = 1'b0;
        mem_waddr_i = $urandom;
        mem_w_sel_i = 4'($urandom);
        mem_data_i  = $urandom;
        #1;
        chk("alu_hold", 32'(hold_flag_o), 32'd0);
        chk("alu_req", 32'(dbus.req), 32'd0);
        @(negedge clk);
        chk("alu_we", 32'(rd_we_o), 32'(we));
        chk("alu_rd", 32'(rd_waddr_o), 32'(rd));
        chk("alu_data", rd_data_o, data);
        chk("alu_pc", inst_addr_o, pc);
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic we,
                           input logic [31:0] pc, input logic [31:0] w,
                           input int gdly, input int rdly,
                           input logic junk_rv);
        int holds;
        holds       = 0;
        inst_i      = {12'h0, 5'd1, f3, rd, OP_LOAD};
        inst_addr_i = pc;
        rd_we_i     = we;
        rd_waddr_i  = rd;
        rd_data_i   = $urandom;
        mem_we_i    = 1'b0;
        mem_waddr_i = a;
        mem_w_sel_i = 4'($urandom);
        mem_data_i  = $urandom;
        #1;
        chk("ld_idle_req", 32'(dbus.req), 32'd0);
        holds += int'(hold_flag_o);
        @(negedge clk);
        for (int i = 0; i <= gdly; i++) begin
            chk("ld_req", 32'(dbus.req), 32'd1);
            chk("ld_addr", dbus.addr, a & 32'hFFFF_FFFC);
            chk("ld_be", 32'(dbus.be), 32'(ref_be(f3, a)));
            chk("ld_we", 32'(dbus.we), 32'd0);
            chk("ld_bubble", 32'(rd_we_o), 32'd0);
            holds += int'(hold_flag_o);
            if (i == gdly) begin
                dbus.gnt = 1'b1;
                if (junk_rv) begin
                    dbus.rvalid = 1'b1;
                    dbus.rdata  = ~w;
                end
            end
            @(negedge clk);
            dbus.gnt    = 1'b0;
            dbus.rvalid = 1'b0;
        end
        for (int i = 0; i <= rdly; i++) begin
            chk("ld_wait_req", 32'(dbus.req), 32'd0);
            chk("ld_wait_bubble", 32'(rd_we_o), 32'd0);
            holds += int'(hold_flag_o);
            if (i == rdly) begin
                dbus.rvalid = 1'b1;
                dbus.rdata  = w;
            end else begin
                dbus.rdata = $urandom;
            end
            @(negedge clk);
            dbus.rvalid = 1'b0;
        end
        chk("ld_done_hold", 32'(hold_flag_o), 32'd0);
        chk("ld_done_bubble", 32'(rd_we_o), 32'd0);
        chk("ld_hold_cycles", 32'(holds), 32'(gdly + rdly + 3));
        @(negedge clk);
        chk("ld_wb_we", 32'(rd_we_o), 32'(we));
        chk("ld_wb_rd", 32'(rd_waddr_o), 32'(rd));
        chk("ld_wb_data", rd_data_o, ref_load(f3, a, w));
        chk("ld_wb_pc", inst_addr_o, pc);
    endtask

    task automatic store_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [3:0] sel, input logic [31:0] d,
                            input logic [31:0] pc, input int gdly);
        int holds;
        int reqs;
        holds       = 0;
        reqs        = 0;
        inst_i      = {7'h0, 5'd2, 5'd1, f3, 5'd0, OP_STORE};
        inst_addr_i = pc;
        rd_we_i     = 1'b1;
        rd_waddr_i  = 5'($urandom);
        rd_data_i   = $urandom;
        mem_we_i    = 1'b1;
        mem_waddr_i = a;
        mem_w_sel_i = sel;
        mem_data_i  = d;
        #1;
        chk("st_idle_req", 32'(dbus.req), 32'd0);
        holds += int'(hold_flag_o);
        @(negedge clk);
        for (int i = 0; i <= gdly; i++) begin
            reqs += int'(dbus.req);
            chk("st_we", 32'(dbus.we), 32'd1);
            chk("st_addr", dbus.addr, a & 32'hFFFF_FFFC);
            chk("st_be", 32'(dbus.be), 32'(sel));
            chk("st_wdata", dbus.wdata, d);
            chk("st_bubble", 32'(rd_we_o), 32'd0);
            holds += int'(hold_flag_o);
            if (i == gdly) dbus.gnt = 1'b1;
            @(negedge clk);
            dbus.gnt = 1'b0;
        end
        chk("st_req_cycles", 32'(reqs), 32'(gdly + 1));
        chk("st_done_req", 32'(dbus.req), 32'd0);
        chk("st_done_hold", 32'(hold_flag_o), 32'd0);
        chk("st_hold_cycles", 32'(holds), 32'(gdly + 2));
        @(negedge clk);
        chk("st_wb_we", 32'(rd_we_o), 32'd0);
    endtask

    task automatic reset_mid_load();
        load_setup: begin
            inst_i      = {12'h0, 5'd1, 3'b010, 5'd7, OP_LOAD};
            inst_addr_i = 32'h0000_0400;
            rd_we_i     = 1'b1;
            rd_waddr_i  = 5'd7;
            rd_data_i   = 32'h5555_5555;
            mem_we_i    = 1'b0;
            mem_waddr_i = 32'h4000_0000;
        end
        @(negedge clk);
        dbus.gnt = 1'b1;
        @(negedge clk);
        dbus.gnt = 1'b0;
        chk("rst_wait_hold", 32'(hold_flag_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_nop();
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'hA5A5_A5A5;
        #1;
        chk("rst_hold", 32'(hold_flag_o), 32'd0);
        chk("rst_req", 32'(dbus.req), 32'd0);
        chk("rst_we", 32'(rd_we_o), 32'd0);
        chk("rst_rd", 32'(rd_waddr_o), 32'd0);
        chk("rst_data", rd_data_o, 32'd0);
        chk("rst_pc", inst_addr_o, 32'd0);
        @(negedge clk);
        dbus.rvalid = 1'b0;
        chk("rst_late_we", 32'(rd_we_o), 32'd0);
        chk("rst_late_hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        chk("rst_after_we", 32'(rd_we_o), 32'd0);
        chk("rst_after_req", 32'(dbus.req), 32'd0);
    endtask

    logic [2:0] ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        rst_n       = 1'b0;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;
        dbus.rdata  = 32'h0;
        drive_nop();
        rd_we_i     = 1'b1;
        rd_data_i   = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("reset_we", 32'(rd_we_o), 32'd0);
        chk("reset_rd", 32'(rd_waddr_o), 32'd0);
        chk("reset_data", rd_data_o, 32'd0);
        chk("reset_pc", inst_addr_o, 32'd0);
        chk("reset_hold", 32'(hold_flag_o), 32'd0);
        chk("reset_req", 32'(dbus.req), 32'd0);
        rst_n = 1'b1;

        alu_op(5'd5, 32'h0000_0012, 32'h0000_0100, 1'b1);
        load_op(3'd2, 32'h1000_0008, 5'd6, 1'b1, 32'h104,
                32'hDEAD_BEEF, 0, 0, 1'b0);
        load_op(3'd0, 32'h3000_0003, 5'd8, 1'b1, 32'h108,
                32'h8000_0000, 0, 0, 1'b0);
        load_op(3'd4, 32'h3000_0003, 5'd9, 1'b1, 32'h10C,
                32'h8000_0000, 1, 2, 1'b0);
        load_op(3'd5, 32'h3000_0002, 5'd10, 1'b1, 32'h110,
                32'h1234_5678, 0, 1, 1'b1);
        store_op(3'd2, 32'h2000_0004, 4'hF, 32'hCAFE_F00D, 32'h114, 3);
        alu_op(5'd11, 32'h0BAD_CAFE, 32'h118, 1'b1);
        reset_mid_load();

`ifdef MEM_MISALIGN_CHK_EN
        inst_i      = {12'h0, 5'd1, 3'b010, 5'd9, OP_LOAD};
        inst_addr_i = 32'h200;
        rd_we_i     = 1'b1;
        rd_waddr_i  = 5'd9;
        mem_we_i    = 1'b0;
        mem_waddr_i = 32'h5000_0002;
        #1;
        chk("mis_hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_req", 32'(dbus.req), 32'd0);
        chk("mis_we", 32'(rd_we_o), 32'd0);
        alu_op(5'd3, 32'h33, 32'h204, 1'b1);
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);
        chk("mis_req_end", 32'(dbus.req), 32'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a    = $urandom;
            if (kind == 0) begin
                alu_op(5'($urandom), $urandom, $urandom, 1'($urandom));
            end else if (kind == 1) begin
                f3 = ld_f3s[$urandom_range(0, 4)];
                load_op(f3, legal_addr(f3, a), 5'($urandom),
                        1'($urandom), $urandom, $urandom,
                        int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), 1'($urandom));
            end else begin
                f3 = 3'($urandom_range(0, 2));
                store_op(f3, legal_addr(f3, a), 4'($urandom), $urandom,
                         $urandom, int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its register-write and memory-request outputs.
- Runs load/store transactions on the data bus through a req/gnt/rvalid handshake, and extracts and sign/zero-extends load data.
- Drives a registered MEM/WB result. Asserts hold_flag_o to the pipeline controller while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of dbus_addr_o. It takes the low ADDR_WIDTH bits of mem_waddr_i, with bits [1:0] forced to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous active-low
- inst_i  in  32  instruction from EX/MEM; opcode and funct3 are decoded here
- inst_addr_i  in  32  PC of inst_i
- rd_we_i  in  1  register write enable from EX/MEM
- rd_waddr_i  in  5  destination register
- rd_data_i  in  32  ALU result
- mem_we_i  in  1  store request
- mem_waddr_i  in  32  effective address; EX supplies it for both loads and stores
- mem_w_sel_i  in  4  store byte enables, already lane-aligned by EX
- mem_data_i  in  32  store data, already lane-aligned by EX
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  ADDR_WIDTH  word-aligned address
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  write data
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  read data valid
- dbus_rdata_i  in  32  read data
- rd_we_o  out  1  to WB (registered)
- rd_waddr_o  out  5  to WB (registered)
- rd_data_o  out  32  to WB (registered)
- inst_addr_o  out  32  to WB (registered)
- hold_flag_o  out  1  to ctrl; combinational stall request

Behaviour:
- Reset (rst_n=0 at a clk edge): state returns to IDLE; all registered outputs clear to 0; dbus_req_o=0; hold_flag_o=0. This applies mid-transaction too: a pending req is dropped and a late gnt or rvalid is ignored.
- Access detection:
  - load = inst_i[6:0]==7'b0000011;
  - store = mem_we_i;
  - access = load | store.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - No access: rd_* and inst_addr_i are registered into the outputs at the next edge, so non-memory latency is 1 cycle. hold_flag_o=0.
  - Access: hold_flag_o=1 combinationally in the same cycle. Address, funct3, rd_waddr, be, wdata and we are latched, and the state moves to REQ.
- REQ: dbus_req_o=1 with the latched fields held stable. The state stays in REQ until dbus_gnt_i=1. On gnt: a store goes to DONE, a load goes to WAIT_R. hold_flag_o=1.
- WAIT_R: dbus_req_o=0, hold_flag_o=1. On dbus_rvalid_i=1, dbus_rdata_i is captured, the extracted value is formed, and the state moves to DONE.
- DONE: hold_flag_o=0 and EX/MEM inputs are ignored (EX/MEM advances at this edge). At the edge the result is written:
  - Load: rd_we_o=rd_we_i latch, rd_waddr_o=latched rd, rd_data_o=extracted value.
  - Store: rd_we_o=0.
  - Next state is IDLE.
- Bubble rule: during REQ and WAIT_R the output register loads rd_we_o=0, so WB sees bubbles, never duplicate writes.
- Load byte enables, with off=mem_waddr_i[1:0]:
  - LB/LBU: 4'b0001<<off;
  - LH/LHU: 4'b0011<<{off[1],1'b0};
  - LW: 4'b1111.
- Load extraction from the captured word:
  - LB: byte at lane off, sign-extended. LBU: same byte, zero-extended.
  - LH: halfword at lane off[1], sign-extended. LHU: same halfword, zero-extended.
  - LW: full word.
  - Other funct3 values: full word.
- Stores: dbus_be_o=mem_w_sel_i, dbus_wdata_o=mem_data_i, unmodified.
- gnt may arrive in the first REQ cycle. rvalid is never sampled in the same cycle as gnt; it is sampled from WAIT_R onward.
- Best case: a load completes in 4 edges and a store in 3 edges from entering IDLE with access. There is no timeout.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- Enabled:
  - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Store width is taken from inst_i funct3.
  - Behaviour on a misaligned access: no bus request is issued and the FSM stays in IDLE. hold_flag_o=0. The output register loads rd_we_o=0. Added output port misalign_o (1 bit, registered) pulses 1 for one cycle.
- Disabled:
  - Port misalign_o is absent.
  - Halfword accesses use addr[1] only; word accesses ignore addr[1:0]. No check is made.

Test Plan:
- ADD x5 result 0x0000_0012, rd_we_i=1, no access -> next edge rd_we_o=1, rd_waddr_o=5, rd_data_o=0x12; hold_flag_o never high.
- LW at 0x1000_0008, gnt same cycle, rvalid next cycle with 0xDEAD_BEEF -> dbus_addr_o=0x1000_0008, be=4'b1111, hold high 3 cycles, rd_data_o=0xDEAD_BEEF.
- LB at 0x...0003, rdata 0x8000_0000 -> be=4'b1000, rd_data_o=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU at 0x...0002, rdata 0x1234_5678 -> 0x0000_1234.
- SW 0xCAFE_F00D to 0x2000_0004, gnt delayed 3 cycles -> dbus_req_o held 4 cycles with stable address/data, dbus_we_o=1, rd_we_o=0 throughout.
- LW with gnt then rst_n=0 in WAIT_R, and rvalid arriving after reset -> outputs 0, IDLE, no write to WB.
- With MEM_MISALIGN_CHK_EN: LW at 0x...0002 -> no dbus_req_o, misalign_o=1 for one cycle, rd_we_o=0.
